instruction_iot601x: RTL and testbench

INSTRUCTION_IOT601X -- requirements
Module: instruction_iot601x
Paper-tape reader (PR8-E style, IOT 601x) fed by a UART 8N1 receiver with 4-entry byte FIFO; drives the CPU skip/AC-OR/done paths.

---
 rtl/instruction_iot601x.sv | 183 ++++++++++++++++++
 tb/tb_instruction_iot601x.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_iot601x.sv
// Paper-tape reader IOT 601x: UART 8N1 receiver feeding a 4-byte FIFO,
// decoded against the CPU sequencer phases to produce skip, AC-OR and done.
module instruction_iot601x #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        clear,
  input  logic        EN,
  input  logic [2:0]  IR,
  input  logic        ck1,
  input  logic        ck2,
  input  logic        ck3,
  input  logic        ck4,
  input  logic        ck5,
  input  logic        ck6,
  input  logic        stb1,
  input  logic        stb2,
  input  logic        stb3,
  input  logic        stb4,
  input  logic        stb5,
  input  logic        stb6,
  input  logic        rx,
  output logic        done,
  output logic        pc_ck,
  output logic        rot2ac,
  output logic        ac_ck,
  output logic [11:0] ACRDR,
  output logic        irq,
  output logic        overrun
);

  localparam logic [11:0] HALF_M1 = 12'(CLKS_PER_BIT / 2 - 1);
  localparam logic [11:0] BIT_M1  = 12'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  // Synchronizer stages plus one history flop for falling-edge detection
  logic       rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_s3_q, rx_s3_d;
  rx_state_t  state_q, state_d;
  logic [11:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       push_q, push_d;

  logic [7:0] fifo_mem_q [4];
  logic [7:0] fifo_mem_d [4];
  logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic       ie_q, ie_d, ovr_q, ovr_d;

  logic       flag, full, pop, push_ok, rpe;
  logic [7:0] head;
  logic       unused_inputs;

  // Receiver next-state: start is re-checked at mid-bit to reject glitches
  always_comb begin
    rx_s1_d = rx;
    rx_s2_d = rx_s1_q;
    rx_s3_d = rx_s2_q;
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    push_d  = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!rx_s2_q && rx_s3_q) state_d = START;
      end
      START: begin
        if (baud_q == HALF_M1) begin
          baud_d  = '0;
          state_d = rx_s2_q ? IDLE : DATA;
        end else begin
          baud_d = baud_q + 12'd1;
        end
      end
      DATA: begin
        if (baud_q == BIT_M1) begin
          baud_d  = '0;
          shift_d = {rx_s2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + 12'd1;
        end
      end
      default: begin
        if (baud_q == BIT_M1) begin
          baud_d  = '0;
          push_d  = rx_s2_q;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 12'd1;
        end
      end
    endcase
  end

  assign flag    = (count_q != 3'd0);
  assign full    = (count_q == 3'd4);
  assign head    = fifo_mem_q[rd_ptr_q];
  assign pop     = stb3 & EN & (IR[1] | IR[2]) & flag;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign push_ok = push_q & (~full | pop);
  assign rpe     = stb1 & EN & (IR == 3'b000);

  // FIFO, interrupt enable and overrun next-state; clear overrides any push
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ie_d       = ie_q;
    ovr_d      = ovr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ie_d     = 1'b0;
      ovr_d    = 1'b0;
    end else begin
      if (push_ok) begin
        fifo_mem_d[wr_ptr_q] = shift_q;
        wr_ptr_d = wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
      count_d = count_q + 3'(push_ok) - 3'(pop);
      if (push_q && full && !pop) ovr_d = 1'b1;
      if (rpe) ie_d = 1'b1;
    end
  end

  // All state registers; reset returns line-idle synchronizer and empty FIFO
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      push_q     <= 1'b0;
      fifo_mem_q <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ie_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_s3_q    <= rx_s3_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      push_q     <= push_d;
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ie_q       <= ie_d;
      ovr_q      <= ovr_d;
    end
  end

  // CPU-side outputs are forced low while RESET is held
  assign done    = ~RESET & ck4 & EN;
  assign pc_ck   = ~RESET & stb1 & EN & IR[0] & flag;
  assign rot2ac  = ~RESET & ck2 & EN & IR[1];
  assign ac_ck   = ~RESET & stb2 & EN & IR[1];
  assign ACRDR   = (~RESET & ck2 & EN & IR[1] & flag) ? {4'b0000, head} : 12'd0;
  assign irq     = ~RESET & ie_q & flag;
  assign overrun = ~RESET & ovr_q;

  // Phases this instruction group never uses
  assign unused_inputs = ^{ck1, ck3, ck5, ck6, stb4, stb5, stb6};

endmodule

// File: tb/tb_instruction_iot601x.sv
// Directed bench for the IOT 601x tape reader at CLKS_PER_BIT = 16.
module tb_instruction_iot601x;

  localparam int CPB = 16;

  logic CLK, RESET, clear, EN, rx;
  logic [2:0] IR;
  logic ck1, ck2, ck3, ck4, ck5, ck6, stb1, stb2, stb3, stb4, stb5, stb6;
  logic done, pc_ck, rot2ac, ac_ck, irq, overrun;
  logic [11:0] ACRDR;

  int n_cmp = 0;
  int n_fail = 0;
  int obs_pc, obs_rot, obs_acck, obs_done, obs_done_bad, obs_acrdr_bad;
  logic [11:0] obs_acrdr;
  int irq_rise;

  instruction_iot601x #(.CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK), .RESET(RESET), .clear(clear), .EN(EN), .IR(IR),
    .ck1(ck1), .ck2(ck2), .ck3(ck3), .ck4(ck4), .ck5(ck5), .ck6(ck6),
    .stb1(stb1), .stb2(stb2), .stb3(stb3), .stb4(stb4), .stb5(stb5), .stb6(stb6),
    .rx(rx), .done(done), .pc_ck(pc_ck), .rot2ac(rot2ac), .ac_ck(ac_ck),
    .ACRDR(ACRDR), .irq(irq), .overrun(overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_phase(input int k, input logic c, input logic s);
    ck1 = c && (k == 1); ck2 = c && (k == 2); ck3 = c && (k == 3);
    ck4 = c && (k == 4); ck5 = c && (k == 5); ck6 = c && (k == 6);
    stb1 = s && (k == 1); stb2 = s && (k == 2); stb3 = s && (k == 3);
    stb4 = s && (k == 4); stb5 = s && (k == 5); stb6 = s && (k == 6);
  endtask

  // One instruction: six phases of three cycles, strobe on the middle cycle
  task automatic run_iot(input logic [2:0] ir);
    obs_pc = 0; obs_rot = 0; obs_acck = 0; obs_done = 0; obs_done_bad = 0;
    obs_acrdr_bad = 0; obs_acrdr = 12'hFFF;
    EN = 1'b1; IR = ir;
    for (int k = 1; k <= 6; k++) begin
      for (int j = 0; j < 3; j++) begin
        drive_phase(k, 1'b1, j == 1);
        #2;
        if (pc_ck) obs_pc++;
        if (rot2ac) obs_rot++;
        if (ac_ck) obs_acck++;
        if (done) begin obs_done++; if (k != 4) obs_done_bad++; end
        if (k == 2 && j == 1) obs_acrdr = ACRDR;
        if (k != 2 && ACRDR !== 12'd0) obs_acrdr_bad++;
        tick();
      end
    end
    drive_phase(0, 1'b0, 1'b0); EN = 1'b0; IR = 3'b000;
    tick();
    $display("iot 601%0o acrdr=%04o pc_ck=%0d done=%0d", ir, obs_acrdr, obs_pc, obs_done);
  endtask

  // Serial frame; optional RRB pop strobe injected at cycle pop_at after the start edge
  task automatic send_byte(input logic [7:0] b, input logic stop, input int pop_at);
    logic [9:0] frame;
    int c;
    frame = {stop, b, 1'b0};
    irq_rise = -1;
    c = 0;
    for (int bi = 0; bi < 10; bi++) begin
      for (int j = 0; j < CPB; j++) begin
        if (j == 0) rx = frame[bi];
        if (pop_at >= 0) begin
          EN = (c == pop_at); IR = 3'b010; stb3 = (c == pop_at);
        end
        if (irq && irq_rise < 0) irq_rise = c;
        tick();
        c++;
      end
    end
    rx = 1'b1;
    if (pop_at >= 0) begin EN = 1'b0; IR = 3'b000; stb3 = 1'b0; end
    for (int j = 0; j < 8; j++) begin
      if (irq && irq_rise < 0) irq_rise = c;
      tick();
      c++;
    end
    $display("rx  byte=%02h stop=%0d irq_rise=%0d", b, stop, irq_rise);
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(); clear = 1'b0; tick();
  endtask

  task automatic test_reset();
    EN = 1'b1; IR = 3'b011; ck2 = 1'b1; ck4 = 1'b1; stb1 = 1'b1; stb2 = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({done, pc_ck, rot2ac, ac_ck, irq, overrun, ACRDR} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", {done, pc_ck, rot2ac, ac_ck, irq, overrun, ACRDR});
    end
    EN = 1'b0;
    RESET = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({done, pc_ck, rot2ac, ac_ck, irq, overrun, ACRDR} !== 18'd0) begin
      n_fail++;
      $display("FAIL no_en_outputs: got %h want 0", {done, pc_ck, rot2ac, ac_ck, irq, overrun, ACRDR});
    end
    drive_phase(0, 1'b0, 1'b0); IR = 3'b000;
    repeat (4) tick();
  endtask

  task automatic test_rx_5a();
    run_iot(3'b000);
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_empty: got %b want 0", irq); end
    send_byte(8'h5A, 1'b1, -1);
    n_cmp++;
    if (irq_rise < 0 || irq_rise > 168) begin
      n_fail++; $display("FAIL flag_latency: got %0d cycles want 0..168", irq_rise);
    end
    run_iot(3'b010);
    n_cmp++;
    if (obs_acrdr !== 12'o0132) begin n_fail++; $display("FAIL rrb_5a: got %04o want 0132", obs_acrdr); end
    n_cmp++;
    if (obs_rot !== 3 || obs_acck !== 1 || obs_done !== 3 || obs_done_bad !== 0 || obs_acrdr_bad !== 0) begin
      n_fail++;
      $display("FAIL rrb_ctl: got rot=%0d ac_ck=%0d done=%0d/%0d bad=%0d want 3 1 3/0 0",
               obs_rot, obs_acck, obs_done, obs_done_bad, obs_acrdr_bad);
    end
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL empty_after_rrb: irq got %b want 0", irq); end
  endtask

  task automatic test_rsf();
    run_iot(3'b001);
    n_cmp++;
    if (obs_pc !== 0 || obs_done !== 3) begin
      n_fail++; $display("FAIL rsf_empty: pc_ck=%0d done=%0d want 0 3", obs_pc, obs_done);
    end
    send_byte(8'h33, 1'b1, -1);
    run_iot(3'b001);
    n_cmp++;
    if (obs_pc !== 1) begin n_fail++; $display("FAIL rsf_full: pc_ck=%0d want 1", obs_pc); end
    run_iot(3'b010);
    n_cmp++;
    if (obs_acrdr !== 12'h033) begin n_fail++; $display("FAIL rrb_33: got %03h want 033", obs_acrdr); end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, -1);
    n_cmp++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b want 1", overrun); end
    for (int i = 1; i <= 4; i++) begin
      run_iot(3'b010);
      n_cmp++;
      if (obs_acrdr !== 12'(i)) begin n_fail++; $display("FAIL ovr_read%0d: got %03h want %03h", i, obs_acrdr, 12'(i)); end
    end
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL ovr_empty: irq got %b want 0", irq); end
    run_iot(3'b010);
    n_cmp++;
    if (obs_acrdr !== 12'd0 || obs_acck !== 1) begin
      n_fail++; $display("FAIL rrb_empty: acrdr=%03h ac_ck=%0d want 000 1", obs_acrdr, obs_acck);
    end
    pulse_clear();
    n_cmp++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL clear_overrun: got %b want 0", overrun); end
    run_iot(3'b000);
  endtask

  task automatic test_bad_frames();
    send_byte(8'h3C, 1'b0, -1);
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL stop_low: irq got %b want 0", irq); end
    rx = 1'b0; repeat (CPB / 4) tick();
    rx = 1'b1; repeat (12 * CPB) tick();
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL glitch: irq got %b want 0", irq); end
    send_byte(8'h81, 1'b1, -1);
    run_iot(3'b010);
    n_cmp++;
    if (obs_acrdr !== 12'h081) begin n_fail++; $display("FAIL after_bad: got %03h want 081", obs_acrdr); end
  endtask

  task automatic test_rpe_rfc();
    pulse_clear();
    send_byte(8'h77, 1'b1, -1);
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_no_ie: got %b want 0", irq); end
    run_iot(3'b000);
    n_cmp++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_ie: got %b want 1", irq); end
    run_iot(3'b100);
    n_cmp++;
    if (obs_acrdr !== 12'd0 || obs_acrdr_bad !== 0 || obs_rot !== 0 || obs_acck !== 0 || obs_pc !== 0) begin
      n_fail++;
      $display("FAIL rfc_quiet: acrdr=%03h bad=%0d rot=%0d ac_ck=%0d pc=%0d want all 0",
               obs_acrdr, obs_acrdr_bad, obs_rot, obs_acck, obs_pc);
    end
    n_cmp++;
    if (obs_done !== 3 || obs_done_bad !== 0) begin
      n_fail++; $display("FAIL rfc_done: got %0d/%0d want 3/0", obs_done, obs_done_bad);
    end
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL rfc_pop: irq got %b want 0", irq); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b1, -1);
    // Push lands on the edge 156 cycles after the start edge; pop strobe sits on that edge
    send_byte(8'h14, 1'b1, 155);
    n_cmp++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL coincident_ovr: got %b want 0", overrun); end
    for (int i = 1; i <= 4; i++) begin
      run_iot(3'b010);
      n_cmp++;
      if (obs_acrdr !== 12'h010 + 12'(i)) begin
        n_fail++; $display("FAIL coincident_read%0d: got %03h want %03h", i, obs_acrdr, 12'h010 + 12'(i));
      end
    end
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL coincident_empty: irq got %b want 0", irq); end
  endtask

  task automatic test_reset_midbyte();
    logic [7:0] b;
    b = 8'hC3;
    send_byte(8'h99, 1'b1, -1);
    n_cmp++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: got %b want 1", irq); end
    rx = 1'b0; repeat (CPB) tick();
    for (int i = 0; i < 3; i++) begin rx = b[i]; repeat (CPB) tick(); end
    RESET = 1'b1; EN = 1'b1; IR = 3'b011; ck2 = 1'b1; ck4 = 1'b1; stb1 = 1'b1; stb2 = 1'b1;
    #1;
    n_cmp++;
    if ({done, pc_ck, rot2ac, ac_ck, irq, overrun, ACRDR} !== 18'd0) begin
      n_fail++;
      $display("FAIL midbyte_reset_outputs: got %h want 0", {done, pc_ck, rot2ac, ac_ck, irq, overrun, ACRDR});
    end
    for (int i = 3; i < 8; i++) begin rx = b[i]; repeat (CPB) tick(); end
    rx = 1'b1; repeat (CPB) tick();
    drive_phase(0, 1'b0, 1'b0); EN = 1'b0; IR = 3'b000;
    RESET = 1'b0;
    repeat (20) tick();
    run_iot(3'b000);
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL post_reset_empty: irq got %b want 0", irq); end
    send_byte(8'hA5, 1'b1, -1);
    run_iot(3'b010);
    n_cmp++;
    if (obs_acrdr !== 12'h0A5) begin n_fail++; $display("FAIL post_reset_rx: got %03h want 0a5", obs_acrdr); end
  endtask

  initial begin
    RESET = 1'b1; clear = 1'b0; EN = 1'b0; IR = 3'b000; rx = 1'b1;
    drive_phase(0, 1'b0, 1'b0);
    test_reset();
    test_rx_5a();
    test_rsf();
    test_overrun();
    test_bad_frames();
    test_rpe_rfc();
    test_back_to_back();
    test_reset_midbyte();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
